// File: rtl/universal_shift_reg.sv
// universal_shift_reg: N-bit universal shift register; multi-bit shift/rotate ops run one bit per cycle
// under a start/busy/done handshake, with every output registered.
module universal_shift_reg #(
    parameter int N     = 8,
    parameter int CNT_W = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [CNT_W-1:0] amount,
    input  logic [N-1:0]     parallel_in,
    input  logic             ser_in,
    output logic [N-1:0]     parallel_out,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);
    typedef enum logic {IDLE, SHIFT} state_t;
    localparam logic [2:0] LOAD = 3'd1, SHL = 3'd2, SHR = 3'd3, SAR = 3'd4, ROL = 3'd5, ROR = 3'd6;
    localparam logic [CNT_W-1:0] N_C = CNT_W'(N);
    state_t           state;
    logic [2:0]       op_q;
    logic [CNT_W-1:0] cnt, eff;
    logic [N-1:0]     r_reg, r_next;
    logic             so_next, shift_op;
    assign parallel_out = r_reg;
    assign eff          = amount > N_C ? N_C : amount;
    assign shift_op     = op >= SHL && op <= ROR;
    // One step of the latched operation; only meaningful in SHIFT.
    always_comb begin
        r_next  = r_reg;
        so_next = ser_out;
        case (op_q)
            SHL: begin r_next = {r_reg[N-2:0], ser_in};    so_next = r_reg[N-1]; end
            SHR: begin r_next = {ser_in, r_reg[N-1:1]};    so_next = r_reg[0];   end
            SAR: begin r_next = {r_reg[N-1], r_reg[N-1:1]}; so_next = r_reg[0];  end
            ROL: begin r_next = {r_reg[N-2:0], r_reg[N-1]}; so_next = r_reg[N-1]; end
            ROR: begin r_next = {r_reg[0], r_reg[N-1:1]};  so_next = r_reg[0];   end
            default: ;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            op_q    <= 3'd0;
            cnt     <= '0;
            r_reg   <= '0;
            ser_out <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else if (state == IDLE) begin
            done <= 1'b0;
            if (start) begin
                if (op == LOAD)
                    r_reg <= parallel_in;
                if (shift_op && eff != '0) begin
                    state <= SHIFT;
                    op_q  <= op;
                    cnt   <= eff;
                    busy  <= 1'b1;
                end else begin
                    done <= 1'b1;
                end
            end
        end else begin
            r_reg   <= r_next;
            ser_out <= so_next;
            cnt     <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_universal_shift_reg.sv
// tb_universal_shift_reg: randomized scoreboard bench; expected results come from a closed-form
// shift/rotate model and are checked by a monitor on every done pulse.
module tb_universal_shift_reg;
    localparam int N     = 8;
    localparam int CNT_W = $clog2(N + 1);
    typedef struct {
        logic [N-1:0] r;
        logic         so;
        int           b;
    } exp_t;
    logic             clk = 0, rst_n = 0, start = 0, ser_in = 0;
    logic [2:0]       op = 0;
    logic [CNT_W-1:0] amount = 0;
    logic [N-1:0]     parallel_in = 0, parallel_out;
    logic             ser_out, busy, done;
    exp_t             q[$];
    logic [N-1:0]     m_r = 0;
    logic             m_so = 0;
    int               checks = 0, errors = 0, bcnt = 0;
    universal_shift_reg #(.N(N), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .amount(amount),
        .parallel_in(parallel_in), .ser_in(ser_in), .parallel_out(parallel_out),
        .ser_out(ser_out), .busy(busy), .done(done)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask
    // Whole-operation result computed in one go from the operation's definition.
    task automatic model(input logic [2:0] o, input int a, input logic [N-1:0] p, input logic s, output exp_t e);
        int k;
        logic [2*N-1:0] w;
        k = a > N ? N : a;
        e.r = m_r; e.so = m_so; e.b = 0;
        if (o == 3'd1) e.r = p;
        else if (o >= 3'd2 && o <= 3'd6 && k > 0) begin
            e.b = k;
            case (o)
                3'd2: begin w = {m_r, {N{s}}} << k; e.r = w[2*N-1:N]; e.so = m_r[N-k]; end
                3'd3: begin w = {{N{s}}, m_r} >> k; e.r = w[N-1:0];   e.so = m_r[k-1]; end
                3'd4: begin e.r = $signed(m_r) >>> k;                 e.so = m_r[k-1]; end
                3'd5: begin w = {m_r, m_r} << k;    e.r = w[2*N-1:N]; e.so = m_r[N-k]; end
                default: begin w = {m_r, m_r} >> k; e.r = w[N-1:0];   e.so = m_r[k-1]; end
            endcase
        end
        m_r = e.r; m_so = e.so;
    endtask
    always @(negedge clk) begin
        if (!rst_n) bcnt = 0;
        else begin
            if (busy) bcnt++;
            if (done) begin
                if (q.size() == 0) chk("unexpected_done", 1, 0);
                else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("parallel_out", parallel_out, e.r);
                    chk("ser_out", ser_out, e.so);
                    chk("busy_cycles", bcnt, e.b);
                end
                bcnt = 0;
            end
        end
    end
    task automatic wait_done();
        bit seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin seen = 1; break; end
            @(negedge clk);
        end
        chk("done_seen", seen, 1);
    endtask
    task automatic begin_op(input logic [2:0] o, input int a, input logic [N-1:0] p, input logic s);
        @(negedge clk);
        start = 1; op = o; amount = CNT_W'(a); parallel_in = p; ser_in = s;
        @(negedge clk);
        start = 0; op = 3'($urandom); amount = CNT_W'($urandom); parallel_in = N'($urandom);
    endtask
    task automatic issue(input logic [2:0] o, input int a, input logic [N-1:0] p, input logic s);
        exp_t e;
        model(o, a, p, s, e);
        q.push_back(e);
        begin_op(o, a, p, s);
        wait_done();
    endtask
    task automatic check_reset_outputs(input string tag);
        chk({tag, "_par"}, parallel_out, 0);
        chk({tag, "_ser"}, ser_out, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask
    task automatic async_reset();
        #2 rst_n = 0;
        #1 check_reset_outputs("async_rst");
        q.delete(); m_r = 0; m_so = 0;
        @(negedge clk); @(negedge clk);
        rst_n = 1;
    endtask
    initial begin
        #1 check_reset_outputs("por");
        @(negedge clk); @(negedge clk);
        rst_n = 1;
        issue(3'd1, 0, 8'h6D, 0);
        issue(3'd2, 2, 0, 1);
        @(negedge clk);
        async_reset();
        repeat (3) begin @(negedge clk); check_reset_outputs("idle"); end
        issue(3'd1, 0, 8'hA5, 0);
        issue(3'd2, 0, 0, 0);
        issue(3'd2, 3, 0, 1);
        issue(3'd1, 0, 8'h90, 0);
        issue(3'd4, 2, 0, 1);
        issue(3'd1, 0, 8'h81, 0);
        issue(3'd3, 1, 0, 0);
        issue(3'd1, 0, 8'h3C, 0);
        begin
            exp_t e;
            model(3'd6, 12, 0, 0, e);
            q.push_back(e);
            begin_op(3'd6, 12, 0, 0);
            @(negedge clk);
            start = 1; op = 3'd1; parallel_in = 8'hFF;
            @(negedge clk);
            start = 0;
            wait_done();
            repeat (4) @(negedge clk);
            chk("ror_identity", parallel_out, 8'h3C);
        end
        issue(3'd1, 0, 8'h01, 0);
        begin_op(3'd5, 5, 0, 0);
        @(negedge clk);
        async_reset();
        issue(3'd1, 0, 8'h55, 0);
        for (int i = 0; i < 60; i++)
            issue(3'($urandom), int'($urandom_range(0, 2 ** CNT_W - 1)), N'($urandom), 1'($urandom));
        repeat (4) @(negedge clk);
        chk("scoreboard_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/universal_shift_reg.md
Name: universal_shift_reg

Overview:
- Parametrised N-bit universal shift register; successor to the 4-bit control-coded shift register used in the shift-add multiplier datapath.
- Adds multi-bit shift operations (logical, arithmetic, rotate), executed one bit per cycle under a start/busy/done handshake.
- Serial output is fully registered.
- Feeds the multiplier controller, which issues operations and waits for done.

Parameters:
N, 8, register width in bits (N >= 2)
CNT_W, $clog2(N+1), width of the shift-amount field and internal down-counter

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous reset, active-low
start  input  1  request; sampled only in IDLE
op  input  3  operation: 000 HOLD, 001 LOAD, 010 SHL, 011 SHR, 100 SAR, 101 ROL, 110 ROR, 111 reserved (= HOLD)
amount  input  CNT_W  number of single-bit steps; sampled with start
parallel_in  input  N  load data
ser_in  input  1  fill bit for SHL/SHR, sampled every shift cycle
parallel_out  output  N  current register contents (r_reg)
ser_out  output  1  registered last bit shifted out
busy  output  1  high while a shift sequence is executing
done  output  1  one-cycle completion pulse

Behaviour:
- Reset (rst_n low, asynchronous): r_reg=0, ser_out=0, busy=0, done=0, counter=0, state=IDLE. Takes effect immediately, including mid-sequence; the sequence in progress is discarded.
- States: IDLE and SHIFT. done is a registered pulse, not a separate state.
- IDLE, start=0: register holds; done=0.
- IDLE, start=1, op=HOLD or 111: no change; done=1 for the next cycle.
- IDLE, start=1, op=LOAD: r_reg<=parallel_in at that edge; done=1 for the next cycle; busy stays 0.
- IDLE, start=1, shift op:
  - Latch op and eff=min(amount,N) into the counter.
  - If eff=0: stay IDLE, register unchanged, done=1 next cycle.
  - Otherwise: go to SHIFT, busy=1.
- SHIFT: each edge performs exactly one step and decrements the counter.
  - When the counter goes 1->0: return to IDLE, busy=0, done=1 for one cycle.
  - busy is high for exactly eff cycles; done rises on the edge that completes the last step.
- Step definitions (r = r_reg):
  - SHL: r<={r[N-2:0],ser_in}; ser_out<=r[N-1]
  - SHR: r<={ser_in,r[N-1:1]}; ser_out<=r[0]
  - SAR: r<={r[N-1],r[N-1:1]}; ser_out<=r[0]; ser_in ignored
  - ROL: r<={r[N-2:0],r[N-1]}; ser_out<=r[N-1]
  - ROR: r<={r[0],r[N-1:1]}; ser_out<=r[0]
- ser_out holds its value outside shift steps; LOAD does not change it.
- start while busy: ignored; op, amount and parallel_in are not re-sampled.
- No combinational path from any input to any output; all outputs are registered.
- amount > N saturates to N, so ROL/ROR by N is the identity after N cycles.

Test Plan:
1. rst_n=0 from an arbitrary state -> parallel_out=0, ser_out=0, busy=0, done=0 with no clock edge needed; release, then idle 3 cycles -> outputs stay 0.
2. LOAD parallel_in=8'hA5 -> parallel_out=A5 after one edge, done pulses 1 cycle, busy never 1; then SHL amount=0 -> done pulses, parallel_out stays A5.
3. From A5: SHL amount=3, ser_in=1 -> parallel_out 4B, 97, 2F; ser_out 1, 0, 1; busy high 3 cycles; done high in the cycle after the last step.
4. LOAD 8'h90, then SAR amount=2 -> parallel_out C8, then E4; ser_out 0, 0. LOAD 8'h81, then SHR amount=1, ser_in=0 -> parallel_out 40, ser_out=1.
5. LOAD 8'h3C, then ROR amount=12 (clamped to 8) -> busy exactly 8 cycles, final parallel_out=3C; start with LOAD 8'hFF during busy -> ignored, final value still 3C, exactly one done pulse.
6. ROL amount=5 from 8'h01; drop rst_n during the 2nd SHIFT cycle -> immediate parallel_out=0, busy=0; after release, LOAD 8'h55 accepted normally with done pulse.
